// File: rtl/pc_unit_if.sv
// Control and status bundle between the fetch stage and the program-counter unit.
// The pipeline side drives the next-PC controls (master); pc_unit consumes them (slave).
interface pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    // Next-PC controls
    logic             stall_i;
    logic             redirect_i;
    logic [XLEN-1:0]  redirect_tgt_i;
    logic             half_step_i;
    logic             trap_i;
    logic [XLEN-1:0]  trap_vec_i;

    // PC unit status
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  pc_plus_o;
    logic             misalign_o;
    logic [XLEN-1:0]  badaddr_o;
    logic [CNT_W-1:0] fetch_cnt_o;

    modport master (
        output stall_i,
        output redirect_i,
        output redirect_tgt_i,
        output half_step_i,
        output trap_i,
        output trap_vec_i,
        input  pc_o,
        input  pc_plus_o,
        input  misalign_o,
        input  badaddr_o,
        input  fetch_cnt_o
    );

    modport slave (
        input  stall_i,
        input  redirect_i,
        input  redirect_tgt_i,
        input  half_step_i,
        input  trap_i,
        input  trap_vec_i,
        output pc_o,
        output pc_plus_o,
        output misalign_o,
        output badaddr_o,
        output fetch_cnt_o
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register with sequential / redirect / trap next-PC selection,
// stall, misaligned-redirect fault capture and a fetch counter.
// pc_plus_o is the only combinational output; everything else is registered.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              COMPRESSED   = 1'b0,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic         clk,
    input  logic         reset,
    pc_unit_if.slave     bus
);

    typedef enum logic [0:0] {
        StRun,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  badaddr_q, badaddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  step;
    logic [XLEN-1:0]  pc_plus;
    logic             tgt_misaligned;

    // Sequential increment and redirect alignment check
    always_comb begin
        step = XLEN'(4);
        if (COMPRESSED && bus.half_step_i) begin
            step = XLEN'(2);
        end
        // Wraps modulo 2^XLEN; no carry is reported
        pc_plus = pc_q + step;
        if (COMPRESSED) begin
            tgt_misaligned = bus.redirect_tgt_i[0];
        end else begin
            tgt_misaligned = |bus.redirect_tgt_i[1:0];
        end
    end

    // Next-state / next-PC selection; trap outranks redirect, which outranks stall
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        badaddr_d = badaddr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StRun: begin
                if (bus.trap_i) begin
                    pc_d  = bus.trap_vec_i;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (bus.redirect_i) begin
                    if (tgt_misaligned) begin
                        // Hold PC and counter, remember the offending target
                        badaddr_d = bus.redirect_tgt_i;
                        state_d   = StFault;
                    end else begin
                        pc_d  = bus.redirect_tgt_i;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!bus.stall_i) begin
                    pc_d  = pc_plus;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFault: begin
                // Only a trap leaves the fault; redirect and stall are ignored here
                if (bus.trap_i) begin
                    pc_d    = bus.trap_vec_i;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            pc_q      <= RESET_VECTOR;
            badaddr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            badaddr_q <= badaddr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        bus.pc_o        = pc_q;
        bus.pc_plus_o   = pc_plus;
        bus.misalign_o  = (state_q == StFault);
        bus.badaddr_o   = badaddr_q;
        bus.fetch_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: three instances (default, wrapping reset vector, compressed with a
// narrow counter), directed scenarios plus a randomized run against a reference model.
module tb_pc_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pc_unit_if #(.XLEN(32), .CNT_W(32)) bus_a ();
    pc_unit_if #(.XLEN(32), .CNT_W(32)) bus_b ();
    pc_unit_if #(.XLEN(32), .CNT_W(4))  bus_c ();

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .COMPRESSED(1'b0), .CNT_W(32)
    ) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .COMPRESSED(1'b0), .CNT_W(32)
    ) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .COMPRESSED(1'b1), .CNT_W(4)
    ) u_dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.stall_i = 0; bus_a.redirect_i = 0; bus_a.redirect_tgt_i = '0;
        bus_a.half_step_i = 0; bus_a.trap_i = 0; bus_a.trap_vec_i = '0;
        bus_b.stall_i = 0; bus_b.redirect_i = 0; bus_b.redirect_tgt_i = '0;
        bus_b.half_step_i = 0; bus_b.trap_i = 0; bus_b.trap_vec_i = '0;
        bus_c.stall_i = 0; bus_c.redirect_i = 0; bus_c.redirect_tgt_i = '0;
        bus_c.half_step_i = 0; bus_c.trap_i = 0; bus_c.trap_vec_i = '0;
    endtask

    task automatic set_a(input bit stall, input bit redir, input logic [31:0] tgt,
                         input bit trap, input logic [31:0] vec);
        bus_a.stall_i = stall; bus_a.redirect_i = redir; bus_a.redirect_tgt_i = tgt;
        bus_a.trap_i = trap; bus_a.trap_vec_i = vec;
    endtask

    // Two reset cycles, then release; returns #1 after the release edge
    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus_a.pc_o !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got %h want %h", bus_a.pc_o, 32'h0); end
        checks++; if (bus_a.misalign_o !== 1'b0) begin errors++;
            $display("FAIL reset_misalign: got %b want 0", bus_a.misalign_o); end
        checks++; if (bus_a.badaddr_o !== 32'h0) begin errors++;
            $display("FAIL reset_badaddr: got %h want 0", bus_a.badaddr_o); end
        checks++; if (bus_a.fetch_cnt_o !== 32'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d want 0", bus_a.fetch_cnt_o); end
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL reset_pc_b: got %h want fffffffc", bus_b.pc_o); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        checks++; if (bus_a.pc_o !== 32'h0) begin errors++;
            $display("FAIL seq_pc0: got %h want 0", bus_a.pc_o); end
        // Half-step must be ignored when compressed support is off
        bus_a.half_step_i = 1'b1;
        checks++; if (bus_a.pc_plus_o !== 32'h4) begin errors++;
            $display("FAIL seq_halfstep_ignored: got %h want 4", bus_a.pc_plus_o); end
        bus_a.half_step_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'(i * 4);
            checks++; if (bus_a.pc_o !== exp_pc) begin errors++;
                $display("FAIL seq_pc%0d: got %h want %h", i, bus_a.pc_o, exp_pc); end
        end
        checks++; if (bus_a.fetch_cnt_o !== 32'd3) begin errors++;
            $display("FAIL seq_cnt: got %0d want 3", bus_a.fetch_cnt_o); end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] cnt0;
        set_a(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        cnt0 = bus_a.fetch_cnt_o;
        set_a(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_a.pc_o !== 32'h100) begin errors++;
                $display("FAIL stall_pc%0d: got %h want 100", i, bus_a.pc_o); end
        end
        checks++; if (bus_a.fetch_cnt_o !== cnt0) begin errors++;
            $display("FAIL stall_cnt: got %0d want %0d", bus_a.fetch_cnt_o, cnt0); end
        set_a(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        checks++; if (bus_a.pc_o !== 32'h200) begin errors++;
            $display("FAIL stall_redirect_pc: got %h want 200", bus_a.pc_o); end
        checks++; if (bus_a.fetch_cnt_o !== cnt0 + 1) begin errors++;
            $display("FAIL stall_redirect_cnt: got %0d want %0d", bus_a.fetch_cnt_o, cnt0 + 1); end
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        logic [31:0] pc0;
        logic [31:0] cnt0;
        pc0  = bus_a.pc_o;
        cnt0 = bus_a.fetch_cnt_o;
        set_a(1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
        tick();
        checks++; if (bus_a.pc_o !== pc0) begin errors++;
            $display("FAIL mis_pc_hold: got %h want %h", bus_a.pc_o, pc0); end
        checks++; if (bus_a.misalign_o !== 1'b1) begin errors++;
            $display("FAIL mis_flag: got %b want 1", bus_a.misalign_o); end
        checks++; if (bus_a.badaddr_o !== 32'h102) begin errors++;
            $display("FAIL mis_badaddr: got %h want 102", bus_a.badaddr_o); end
        checks++; if (bus_a.fetch_cnt_o !== cnt0) begin errors++;
            $display("FAIL mis_cnt: got %0d want %0d", bus_a.fetch_cnt_o, cnt0); end
        set_a(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus_a.pc_o !== pc0) begin errors++;
            $display("FAIL mis_ignore_pc: got %h want %h", bus_a.pc_o, pc0); end
        checks++; if (bus_a.misalign_o !== 1'b1) begin errors++;
            $display("FAIL mis_stays: got %b want 1", bus_a.misalign_o); end
        set_a(1'b1, 1'b1, 32'h300, 1'b1, 32'h80);
        tick();
        set_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (bus_a.pc_o !== 32'h80) begin errors++;
            $display("FAIL mis_trap_pc: got %h want 80", bus_a.pc_o); end
        checks++; if (bus_a.misalign_o !== 1'b0) begin errors++;
            $display("FAIL mis_trap_clear: got %b want 0", bus_a.misalign_o); end
        checks++; if (bus_a.fetch_cnt_o !== cnt0 + 1) begin errors++;
            $display("FAIL mis_trap_cnt: got %0d want %0d", bus_a.fetch_cnt_o, cnt0 + 1); end
        checks++; if (bus_a.badaddr_o !== 32'h102) begin errors++;
            $display("FAIL mis_badaddr_kept: got %h want 102", bus_a.badaddr_o); end
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_trap_priority();
        set_a(1'b0, 1'b1, 32'h300, 1'b1, 32'h80);
        tick();
        checks++; if (bus_a.pc_o !== 32'h80) begin errors++;
            $display("FAIL prio_trap_over_redirect: got %h want 80", bus_a.pc_o); end
        set_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h444);
        tick();
        checks++; if (bus_a.pc_o !== 32'h444) begin errors++;
            $display("FAIL prio_trap_over_stall: got %h want 444", bus_a.pc_o); end
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap_vector();
        do_reset();
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_pc0: got %h want fffffffc", bus_b.pc_o); end
        checks++; if (bus_b.pc_plus_o !== 32'h0) begin errors++;
            $display("FAIL wrap_plus0: got %h want 0", bus_b.pc_plus_o); end
        tick();
        checks++; if (bus_b.pc_o !== 32'h0) begin errors++;
            $display("FAIL wrap_pc1: got %h want 0", bus_b.pc_o); end
        checks++; if (bus_b.pc_plus_o !== 32'h4) begin errors++;
            $display("FAIL wrap_plus1: got %h want 4", bus_b.pc_plus_o); end
    endtask

    task automatic test_compressed();
        do_reset();
        bus_c.redirect_i = 1'b1; bus_c.redirect_tgt_i = 32'h10;
        tick();
        bus_c.redirect_i = 1'b0; bus_c.half_step_i = 1'b1; bus_c.stall_i = 1'b1;
        #1;
        checks++; if (bus_c.pc_plus_o !== 32'h12) begin errors++;
            $display("FAIL cmp_plus2: got %h want 12", bus_c.pc_plus_o); end
        bus_c.stall_i = 1'b0;
        tick();
        checks++; if (bus_c.pc_o !== 32'h12) begin errors++;
            $display("FAIL cmp_half_step: got %h want 12", bus_c.pc_o); end
        bus_c.half_step_i = 1'b0;
        bus_c.redirect_i = 1'b1; bus_c.redirect_tgt_i = 32'h22;
        tick();
        checks++; if (bus_c.pc_o !== 32'h22 || bus_c.misalign_o !== 1'b0) begin errors++;
            $display("FAIL cmp_redirect_22: got pc %h mis %b want 22/0",
                     bus_c.pc_o, bus_c.misalign_o); end
        bus_c.redirect_tgt_i = 32'h23;
        tick();
        bus_c.redirect_i = 1'b0;
        checks++; if (bus_c.misalign_o !== 1'b1 || bus_c.badaddr_o !== 32'h23) begin errors++;
            $display("FAIL cmp_fault: got mis %b bad %h want 1/23",
                     bus_c.misalign_o, bus_c.badaddr_o); end
        checks++; if (bus_c.fetch_cnt_o !== 4'd3) begin errors++;
            $display("FAIL cmp_cnt: got %0d want 3", bus_c.fetch_cnt_o); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus_c.pc_o !== 32'h0 || bus_c.misalign_o !== 1'b0 ||
                      bus_c.fetch_cnt_o !== 4'd0) begin errors++;
            $display("FAIL cmp_reset_in_fault: got pc %h mis %b cnt %0d want 0/0/0",
                     bus_c.pc_o, bus_c.misalign_o, bus_c.fetch_cnt_o); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (bus_c.fetch_cnt_o !== 4'd15) begin errors++;
            $display("FAIL cntwrap_15: got %0d want 15", bus_c.fetch_cnt_o); end
        tick();
        checks++; if (bus_c.fetch_cnt_o !== 4'd0) begin errors++;
            $display("FAIL cntwrap_0: got %0d want 0", bus_c.fetch_cnt_o); end
        checks++; if (bus_c.pc_o !== 32'h40) begin errors++;
            $display("FAIL cntwrap_pc: got %h want 40", bus_c.pc_o); end
    endtask

    // Randomized run of instance A against a rule-level model
    task automatic test_random();
        logic [31:0] m_pc, m_bad, m_cnt;
        bit          m_fault;
        bit          stall, redir, trap, rst;
        logic [31:0] tgt, vec;
        do_reset();
        m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0; m_fault = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 4) == 0);
            trap  = ($urandom_range(0, 11) == 0);
            tgt   = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            vec   = $urandom;
            reset = rst;
            set_a(stall, redir, tgt, trap, vec);
            bus_a.half_step_i = 1'($urandom_range(0, 1));
            if (rst) begin
                m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0; m_fault = 1'b0;
            end else if (m_fault) begin
                if (trap) begin m_pc = vec; m_cnt++; m_fault = 1'b0; end
            end else if (trap) begin
                m_pc = vec; m_cnt++;
            end else if (redir) begin
                if (tgt % 4 != 0) begin m_fault = 1'b1; m_bad = tgt; end
                else begin m_pc = tgt; m_cnt++; end
            end else if (!stall) begin
                m_pc = m_pc + 32'd4; m_cnt++;
            end
            tick();
            checks++; if (bus_a.pc_o !== m_pc) begin errors++;
                $display("FAIL rnd_pc[%0d]: got %h want %h", n, bus_a.pc_o, m_pc); end
            checks++; if (bus_a.pc_plus_o !== m_pc + 32'd4) begin errors++;
                $display("FAIL rnd_plus[%0d]: got %h want %h", n, bus_a.pc_plus_o, m_pc + 4); end
            checks++; if (bus_a.misalign_o !== m_fault) begin errors++;
                $display("FAIL rnd_mis[%0d]: got %b want %b", n, bus_a.misalign_o, m_fault); end
            checks++; if (bus_a.badaddr_o !== m_bad) begin errors++;
                $display("FAIL rnd_bad[%0d]: got %h want %h", n, bus_a.badaddr_o, m_bad); end
            checks++; if (bus_a.fetch_cnt_o !== m_cnt) begin errors++;
                $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, bus_a.fetch_cnt_o, m_cnt); end
        end
        reset = 1'b0;
        idle_all();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_all();
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_misalign();
        test_trap_priority();
        test_wrap_vector();
        test_compressed();
        test_cnt_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
